// File: rtl/bit_stream_serializer.sv
// Parallel-to-serial feeder for the 0110 sequence detector.
// Accepts WIDTH-bit words over valid/ready and shifts them out one bit per
// programmable bit period, with a one-cycle ser_en strobe at the end of each
// bit. Back-to-back words stream with no gap between bit periods.
//
// Ports:
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   s_valid    upstream word valid
//   s_ready    word can be accepted this cycle (combinational)
//   s_data     word to serialize
//   msb_first  1 = MSB first, 0 = LSB first; sampled at accept
//   div        bit period minus one, in clk cycles; sampled at accept
//   ser_data   current serial bit (idle high), registered
//   ser_en     end-of-bit-period strobe, registered
//   busy       word in flight, registered
//   word_done  pulse with the last bit's ser_en (combinational)
module bit_stream_serializer #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  input  logic             msb_first,
  input  logic [DIV_W-1:0] div,
  output logic             ser_data,
  output logic             ser_en,
  output logic             busy,
  output logic             word_done
);

  localparam int unsigned BCNT_W = $clog2(WIDTH);
  localparam logic [BCNT_W-1:0] LAST_IDX = BCNT_W'(WIDTH - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   sr_q, sr_d;
  logic [BCNT_W-1:0]  bit_q, bit_d;
  logic [DIV_W-1:0]   per_q, per_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic               ser_data_q, ser_data_d;
  logic               ser_en_q, ser_en_d;
  logic               busy_q, busy_d;

  logic [WIDTH-1:0]   load_word_c;
  logic               last_bit_c;
  logic               load_c;

  // Bit order is resolved at load: the shift register always shifts out its MSB.
  always_comb begin
    load_word_c = s_data;
    if (!msb_first) begin
      for (int i = 0; i < WIDTH; i++) begin
        load_word_c[i] = s_data[WIDTH-1-i];
      end
    end
  end

  // Last bit's strobe cycle: the only SHIFT cycle that can take a new word.
  assign last_bit_c = (state_q == SHIFT) && (per_q == '0) && (bit_q == '0);
  assign word_done  = last_bit_c;
  assign s_ready    = reset_n && ((state_q == IDLE) || last_bit_c);
  assign load_c     = s_valid && s_ready;

  // Next-state and registered-output decode.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    bit_d   = bit_q;
    per_d   = per_q;
    div_d   = div_q;

    if (load_c) begin
      state_d = SHIFT;
      sr_d    = load_word_c;
      bit_d   = LAST_IDX;
      per_d   = div;
      div_d   = div;
    end else if (state_q == SHIFT) begin
      if (per_q == '0) begin
        if (bit_q == '0) begin
          state_d = IDLE;
        end else begin
          sr_d  = {sr_q[WIDTH-2:0], 1'b0};
          bit_d = bit_q - 1'b1;
          per_d = div_q;
        end
      end else begin
        per_d = per_q - 1'b1;
      end
    end

    // Outputs are registered from next state so they line up with the counters.
    ser_data_d = (state_d == SHIFT) ? sr_d[WIDTH-1] : 1'b1;
    ser_en_d   = (state_d == SHIFT) && (per_d == '0);
    busy_d     = (state_d == SHIFT);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      sr_q       <= '0;
      bit_q      <= '0;
      per_q      <= '0;
      div_q      <= '0;
      ser_data_q <= 1'b1;
      ser_en_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      bit_q      <= bit_d;
      per_q      <= per_d;
      div_q      <= div_d;
      ser_data_q <= ser_data_d;
      ser_en_q   <= ser_en_d;
      busy_q     <= busy_d;
    end
  end

  assign ser_data = ser_data_q;
  assign ser_en   = ser_en_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_bit_stream_serializer.sv
// Directed bench for bit_stream_serializer (WIDTH=8, DIV_W=16).
// Outputs are sampled on the falling clock edge; inputs change there too.
module tb_bit_stream_serializer;

  logic        clk;
  logic        reset_n;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  s_data;
  logic        msb_first;
  logic [15:0] div;
  logic        ser_data;
  logic        ser_en;
  logic        busy;
  logic        word_done;

  int n_checks;
  int n_fail;

  bit_stream_serializer #(.WIDTH(8), .DIV_W(16)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .msb_first (msb_first),
    .div       (div),
    .ser_data  (ser_data),
    .ser_en    (ser_en),
    .busy      (busy),
    .word_done (word_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Output vector: {ser_data, ser_en, busy, s_ready, word_done}
  task automatic chk_out(input string tag, input logic [4:0] exp_v);
    chk(tag, 32'({ser_data, ser_en, busy, s_ready, word_done}), 32'(exp_v));
  endtask

  initial begin
    logic [7:0]  w;
    logic [15:0] es;
    logic [3:0]  hist;
    int          det;
    int          pulses;

    n_checks  = 0;
    n_fail    = 0;
    reset_n   = 1'b0;
    s_valid   = 1'b0;
    s_data    = 8'h00;
    msb_first = 1'b1;
    div       = 16'd0;

    // Reset held for 3 cycles, then released with s_valid low.
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      chk_out("reset_hold", 5'b10000);
    end
    reset_n = 1'b1;
    #1;
    chk_out("reset_release", 5'b10010);
    cyc();
    chk_out("idle_after_reset", 5'b10010);

    // Single word 0x66, div=3, MSB first; detector model counts 0110 hits.
    w         = 8'h66;
    s_data    = w;
    div       = 16'd3;
    msb_first = 1'b1;
    s_valid   = 1'b1;
    chk("single_accept_ready", 32'(s_ready), 32'd1);
    cyc();
    s_valid = 1'b0;
    s_data  = 8'h00;
    hist    = 4'b1111;
    det     = 0;
    for (int n = 1; n <= 32; n++) begin
      chk_out("single_word", {w[7-(n-1)/4], (n % 4 == 0), 1'b1, (n == 32), (n == 32)});
      if (ser_en) begin
        hist = {hist[2:0], ser_data};
        if (hist == 4'b0110) det++;
      end
      cyc();
    end
    chk_out("single_back_idle", 5'b10010);
    chk("single_detect_count", 32'(det), 32'd2);

    // Back-to-back 0x0F then 0xF0, LSB first, div=0, s_valid held high.
    es        = 16'b1111_0000_0000_1111;
    s_data    = 8'h0F;
    div       = 16'd0;
    msb_first = 1'b0;
    s_valid   = 1'b1;
    cyc();
    for (int n = 1; n <= 16; n++) begin
      chk_out("b2b_stream", {es[16-n], 1'b1, 1'b1, (n == 8 || n == 16), (n == 8 || n == 16)});
      if (n == 4) s_data = 8'hF0;
      if (n == 16) s_valid = 1'b0;
      cyc();
    end
    chk_out("b2b_idle", 5'b10010);

    // Mid-word div/msb_first/s_data changes are ignored.
    w         = 8'hCA;
    s_data    = w;
    div       = 16'd1;
    msb_first = 1'b1;
    s_valid   = 1'b1;
    cyc();
    s_valid   = 1'b0;
    div       = 16'd5;
    msb_first = 1'b0;
    s_data    = 8'h35;
    for (int n = 1; n <= 16; n++) begin
      chk_out("midword_change", {w[7-(n-1)/2], (n % 2 == 0), 1'b1, (n == 16), (n == 16)});
      cyc();
    end
    chk_out("midword_idle", 5'b10010);

    // Async reset pulse right after the 3rd ser_en.
    s_data    = 8'h66;
    div       = 16'd1;
    msb_first = 1'b1;
    s_valid   = 1'b1;
    cyc();
    s_valid = 1'b0;
    for (int n = 1; n <= 6; n++) begin
      chk("areset_pre_en", 32'(ser_en), 32'(n % 2 == 0));
      if (n < 6) cyc();
    end
    reset_n = 1'b0;
    #1;
    chk_out("areset_immediate", 5'b10000);
    #3;
    reset_n = 1'b1;
    @(negedge clk);
    chk_out("areset_after", 5'b10010);
    pulses = 0;
    for (int n = 0; n < 20; n++) begin
      if (ser_en || busy) pulses++;
      cyc();
    end
    chk("areset_no_activity", 32'(pulses), 32'd0);
    s_data    = 8'h80;
    div       = 16'd0;
    msb_first = 1'b1;
    s_valid   = 1'b1;
    cyc();
    s_valid = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      chk_out("areset_new_word", {(n == 1), 1'b1, 1'b1, (n == 8), (n == 8)});
      cyc();
    end
    chk_out("areset_new_idle", 5'b10010);

    // Max divider: first ser_en exactly 65536 cycles after the accept edge.
    s_data    = 8'h01;
    div       = 16'hFFFF;
    msb_first = 1'b1;
    s_valid   = 1'b1;
    cyc();
    s_valid = 1'b0;
    chk_out("maxdiv_start", 5'b00100);
    pulses = 0;
    for (int n = 1; n < 65536; n++) begin
      if (ser_en) pulses++;
      cyc();
    end
    chk("maxdiv_no_early_en", 32'(pulses), 32'd0);
    chk_out("maxdiv_first_en", 5'b01100);
    cyc();
    chk_out("maxdiv_after_en", 5'b00100);
    reset_n = 1'b0;
    #1;
    chk_out("maxdiv_reset", 5'b10000);
    reset_n = 1'b1;
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
